dram_line_responder: RTL and testbench

Responder end of the external data-memory interface driven by the L1 data cache. It accepts one 256-bit line read or write request at a time, holds it for a fixed access latency, then completes it with a one-cycle acknowledge. It serves as the off-chip DRAM model behind the cache's `ext_mem_*` ports, in both simulation and the top-level testbench.

---
 rtl/dram_line_responder.sv | 131 +++++++++++++
 tb/tb_dram_line_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_line_responder.sv
// Off-chip DRAM line model: one 256-bit read/write at a time, fixed latency, one-cycle ack.
// Optional macro DRAM_RESP_RANGE_CHECK_EN adds err_o and out-of-range request suppression.
module dram_line_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         cs_i,
    input  logic         we_i,
    output logic [255:0] data_o,
    output logic         ack_o,
    output logic         busy_o
`ifdef DRAM_RESP_RANGE_CHECK_EN
    ,
    output logic         err_o
`endif
);

    // state  | meaning
    // S_IDLE | waiting for cs_i; request latched on the accepting edge
    // S_WAIT | latency counter running down to zero
    // S_ACK  | one-cycle completion; read data / error valid here
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [31:0]     lat_addr;
    logic            lat_we;
    logic [255:0]    lat_data;
    logic [255:0]    mem [DEPTH];

    logic [31:0]     req_addr;
    logic            req_we;
    logic [255:0]    req_data;
    logic [AW-1:0]   idx;
    logic            enter_ack;
    logic            oor;
    logic            unused_bits;

    // With LATENCY=1 the ACK edge is the accepting edge, so the live inputs are used there.
    always_comb begin
        req_addr = lat_addr;
        req_we   = lat_we;
        req_data = lat_data;
        if (state == S_IDLE) begin
            req_addr = addr_i;
            req_we   = we_i;
            req_data = data_i;
        end
    end

    assign idx         = req_addr[5 +: AW];
    assign unused_bits = ^{req_addr[4:0], req_addr[31:5+AW]};

`ifdef DRAM_RESP_RANGE_CHECK_EN
    assign oor = |req_addr[31:5+AW];
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        enter_ack = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_i) begin
                    cnt_nx = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nx  = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nx  = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_we   <= 1'b0;
            lat_data <= '0;
            data_o   <= '0;
`ifdef DRAM_RESP_RANGE_CHECK_EN
            err_o    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && cs_i) begin
                lat_addr <= addr_i;
                lat_we   <= we_i;
                lat_data <= data_i;
            end
            data_o <= (enter_ack && !req_we && !oor) ? mem[idx] : '0;
`ifdef DRAM_RESP_RANGE_CHECK_EN
            err_o  <= enter_ack && oor;
`endif
        end
    end

    // Storage is not reset; the rst term keeps an in-reset LATENCY=1 request from writing.
    always_ff @(posedge clk) begin
        if (rst && enter_ack && req_we && !oor)
            mem[idx] <= req_data;
    end

    assign ack_o  = (state == S_ACK);
    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_dram_line_responder.sv
// Directed bench for dram_line_responder: LATENCY=10 instance plus a LATENCY=1 instance.
module tb_dram_line_responder;

    localparam logic [255:0] D1 = {16{16'hA5A5}};
    localparam logic [255:0] D2 = {8{32'h1234_5678}};
    localparam logic [255:0] D3 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D4 = {8{32'h0BAD_F00D}};
    localparam logic [255:0] D5 = {8{32'h5555_AAAA}};
    localparam logic [255:0] D6 = {8{32'hC0FF_EE01}};
    localparam logic [255:0] D7 = {8{32'h7777_0001}};
    localparam logic [255:0] D8 = {8{32'h8888_0002}};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_a, addr_b;
    logic [255:0] data_a, data_b, dout_a, dout_b;
    logic         cs_a, cs_b, we_a, we_b;
    logic         ack_a, ack_b, busy_a, busy_b;
`ifdef DRAM_RESP_RANGE_CHECK_EN
    logic         err_a, err_b;
`endif

    int passed = 0;
    int total  = 0;
    int n, nb, n2, acks;

    always #5 clk = ~clk;

    dram_line_responder #(.DEPTH(512), .LATENCY(10)) u_a (
        .clk(clk), .rst(rst), .addr_i(addr_a), .data_i(data_a), .cs_i(cs_a), .we_i(we_a),
        .data_o(dout_a), .ack_o(ack_a), .busy_o(busy_a)
`ifdef DRAM_RESP_RANGE_CHECK_EN
        , .err_o(err_a)
`endif
    );

    dram_line_responder #(.DEPTH(512), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .addr_i(addr_b), .data_i(data_b), .cs_i(cs_b), .we_i(we_b),
        .data_o(dout_b), .ack_o(ack_b), .busy_o(busy_b)
`ifdef DRAM_RESP_RANGE_CHECK_EN
        , .err_o(err_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Edges until ack is seen (bounded); nbusy counts busy samples along the way.
    task automatic wait_ack(input bit sel, input int maxe, output int ne, output int nbusy);
        ne = 0;
        nbusy = 0;
        do begin
            tick();
            ne++;
            if (sel ? busy_b : busy_a) nbusy++;
        end while (!(sel ? ack_b : ack_a) && ne < maxe);
    endtask

    initial begin
        rst = 1'b0;
        cs_a = 0; we_a = 0; addr_a = '0; data_a = '0;
        cs_b = 0; we_b = 0; addr_b = '0; data_b = '0;
        tick(); tick();
        check("rst_ack", 256'(ack_a), 256'(0));
        check("rst_busy", 256'(busy_a), 256'(0));
        check("rst_data", dout_a, 256'(0));
        check("rst_ack_b", 256'(ack_b), 256'(0));
        rst = 1'b1;
        tick(); tick();
        check("idle_no_cs", 256'(busy_a), 256'(0));

        // Write 0x40, then read it straight after the ack
        addr_a = 32'h40; data_a = D1; we_a = 1; cs_a = 1;
        wait_ack(0, 40, n, nb);
        check("wr_lat", 256'(n), 256'(11));
        check("wr_busy_len", 256'(nb), 256'(11));
        check("wr_data_zero", dout_a, 256'(0));
        we_a = 0;
        tick();
        check("ack_one_cycle", 256'(ack_a), 256'(0));
        check("idle_gap", 256'(busy_a), 256'(0));
        wait_ack(0, 40, n, nb);
        check("rd_lat", 256'(n), 256'(11));
        check("rd_data", dout_a, D1);
        cs_a = 0;
        tick();
        check("rd_data_clr", dout_a, 256'(0));
        tick();

        // cs_i held: write 0x60 then three reads, 12 edges apart
        addr_a = 32'h60; data_a = D2; we_a = 1; cs_a = 1;
        wait_ack(0, 40, n, nb);
        check("wr60_lat", 256'(n), 256'(11));
        we_a = 0; addr_a = 32'h40; data_a = D3;
        wait_ack(0, 40, n, nb);
        check("b2b_gap1", 256'(n), 256'(12));
        check("b2b_rd1", dout_a, D1);
        addr_a = 32'h60;
        repeat (4) tick();
        addr_a = 32'hA0; we_a = 1;
        wait_ack(0, 40, n2, nb);
        check("b2b_gap2", 256'(4 + n2), 256'(12));
        check("b2b_rd2_ignores_change", dout_a, D2);
        addr_a = 32'h40; we_a = 0;
        wait_ack(0, 40, n, nb);
        check("b2b_gap3", 256'(n), 256'(12));
        check("b2b_rd3", dout_a, D1);
        cs_a = 0;
        tick();
        check("b2b_idle", 256'(busy_a), 256'(0));
        tick();

        // Reset in WAIT (count 4) of a write to 0x80 abandons it
        addr_a = 32'h80; data_a = D5; we_a = 1; cs_a = 1;
        wait_ack(0, 40, n, nb);
        cs_a = 0;
        tick();
        data_a = D4; cs_a = 1;
        repeat (6) tick();
        check("mid_busy", 256'(busy_a), 256'(1));
        rst = 1'b0;
        #1;
        check("async_busy", 256'(busy_a), 256'(0));
        check("async_ack", 256'(ack_a), 256'(0));
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack_a) acks++;
        end
        check("no_ack_in_rst", 256'(acks), 256'(0));
        cs_a = 0;
        rst = 1'b1;
        tick();
        we_a = 0; cs_a = 1;
        wait_ack(0, 40, n, nb);
        check("rst_wr_dropped", dout_a, D5);
        cs_a = 0;
        tick();

        // LATENCY=1 instance: write then read 0x20
        addr_b = 32'h20; data_b = D6; we_b = 1; cs_b = 1;
        wait_ack(1, 10, n, nb);
        check("l1_wr_lat", 256'(n), 256'(1));
        check("l1_wr_data_zero", dout_b, 256'(0));
        we_b = 0;
        tick();
        check("l1_idle_gap", 256'(ack_b), 256'(0));
        wait_ack(1, 10, n, nb);
        check("l1_rd_lat", 256'(n), 256'(1));
        check("l1_rd_data", dout_b, D6);
        cs_b = 0;
        tick();

        // Line 512 (0x4000) against line 0
        addr_a = 32'h0; data_a = D7; we_a = 1; cs_a = 1;
        wait_ack(0, 40, n, nb);
        cs_a = 0;
        tick();
        addr_a = 32'h4000; data_a = D8; cs_a = 1;
        wait_ack(0, 40, n, nb);
        check("oor_lat", 256'(n), 256'(11));
`ifdef DRAM_RESP_RANGE_CHECK_EN
        check("oor_err", 256'(err_a), 256'(1));
`endif
        cs_a = 0;
        tick();
`ifdef DRAM_RESP_RANGE_CHECK_EN
        check("oor_err_clr", 256'(err_a), 256'(0));
`endif
        addr_a = 32'h0; we_a = 0; cs_a = 1;
        wait_ack(0, 40, n, nb);
`ifdef DRAM_RESP_RANGE_CHECK_EN
        check("line0_kept", dout_a, D7);
`else
        check("line0_aliased", dout_a, D8);
`endif
        cs_a = 0;
        tick();
`ifdef DRAM_RESP_RANGE_CHECK_EN
        addr_a = 32'h4000; cs_a = 1;
        wait_ack(0, 40, n, nb);
        check("oor_rd_zero", dout_a, 256'(0));
        check("oor_rd_err", 256'(err_a), 256'(1));
        cs_a = 0;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
